// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the two-port data RAM arbiter: lock states, port ids,
// access size codes and the response-tracking record.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_UNLOCKED = 2'd0,
    ARB_LOCKED0  = 2'd1,
    ARB_LOCKED1  = 2'd2
  } arb_state_e;

  typedef enum logic {
    ARB_P0 = 1'b0,
    ARB_P1 = 1'b1
  } arb_port_e;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  // One in-flight read: whether the slot holds a read and which port issued it.
  typedef struct packed {
    logic      valid;
    arb_port_e port;
  } arb_resp_t;

  function automatic arb_port_e other_port(arb_port_e p);
    return (p == ARB_P0) ? ARB_P1 : ARB_P0;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester-side port bundle of the RAM arbiter. The requester drives the
// access fields (master); the arbiter returns grant and read response (slave).
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic              req;
  logic              we;
  logic              lock;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [1:0]        size;
  logic              rd_signed;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, we, lock, addr, wdata, size, rd_signed,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, lock, addr, wdata, size, rd_signed,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/mem_port_arbiter_resp_pipe.sv
// Read-response tracker: RD_LAT stages of {valid, port id}, so each read's
// response is tagged with its issuing port when the RAM data appears.
module mem_arb_resp_pipe
  import mem_port_arbiter_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic      clk,
  input  logic      rst,
  input  arb_resp_t resp_in,
  output arb_resp_t resp_out
);

  arb_resp_t stage_q [RD_LAT];

  // Shift one stage per cycle; reset drops every in-flight read.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= resp_in;
      for (int i = 1; i < RD_LAT; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign resp_out = stage_q[RD_LAT-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-port data RAM arbiter: round-robin grant with optional lock ownership,
// lock timeout, RAM field mux and read-response routing.
//
// state        | meaning
// ARB_UNLOCKED | round-robin between both ports
// ARB_LOCKED0  | port 0 owns the RAM; port 1 waits
// ARB_LOCKED1  | port 1 owns the RAM; port 0 waits
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 32,
  parameter int RD_LAT   = 1,
  parameter int LOCK_TMO = 15
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave p0,
  mem_port_arbiter_if.slave p1,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic [1:0]        ram_write_mode,
  output logic [1:0]        ram_read_mode,
  output logic              ram_read_signed,
  input  logic [DATA_W-1:0] ram_rdata
);

  // Release fires on the cycle the idle count has already seen LOCK_TMO-1 idle cycles.
  localparam logic [7:0] TMO_LAST = 8'(LOCK_TMO - 1);

  arb_state_e state_q, state_d;
  arb_port_e  last_q, last_d;
  logic [7:0] idle_cnt_q, idle_cnt_d;
  logic       gnt0, gnt1;
  logic       owner_gnt, owner_lock;
  arb_resp_t  resp_in, resp_out;
  logic       rvalid0, rvalid1;

  // Grant: owner-only while locked, otherwise the single requester or the port not served last.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      case (state_q)
        ARB_LOCKED0: gnt0 = p0.req;
        ARB_LOCKED1: gnt1 = p1.req;
        default: begin
          if (p0.req && p1.req) begin
            gnt0 = (other_port(last_q) == ARB_P0);
            gnt1 = (other_port(last_q) == ARB_P1);
          end else begin
            gnt0 = p0.req;
            gnt1 = p1.req;
          end
        end
      endcase
    end
  end

  assign owner_gnt  = (state_q == ARB_LOCKED1) ? gnt1    : gnt0;
  assign owner_lock = (state_q == ARB_LOCKED1) ? p1.lock : p0.lock;

  // Lock FSM next state, idle timeout counter and round-robin pointer.
  always_comb begin
    state_d    = state_q;
    idle_cnt_d = idle_cnt_q;
    last_d     = last_q;
    if (gnt0) begin
      last_d = ARB_P0;
    end else if (gnt1) begin
      last_d = ARB_P1;
    end
    case (state_q)
      ARB_UNLOCKED: begin
        idle_cnt_d = '0;
        if (gnt0 && p0.lock) begin
          state_d = ARB_LOCKED0;
        end else if (gnt1 && p1.lock) begin
          state_d = ARB_LOCKED1;
        end
      end
      ARB_LOCKED0, ARB_LOCKED1: begin
        if (owner_gnt) begin
          idle_cnt_d = '0;
          if (!owner_lock) begin
            state_d = ARB_UNLOCKED;
          end
        end else if (idle_cnt_q == TMO_LAST) begin
          idle_cnt_d = '0;
          state_d    = ARB_UNLOCKED;
        end else begin
          idle_cnt_d = idle_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d    = ARB_UNLOCKED;
        idle_cnt_d = '0;
      end
    endcase
  end

  // State register; the pointer resets to "p1 served last" so p0 wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ARB_UNLOCKED;
      last_q     <= ARB_P1;
      idle_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      idle_cnt_q <= idle_cnt_d;
    end
  end

  // RAM field mux: granted port's fields, all zero when nothing is granted.
  always_comb begin
    ram_we          = 1'b0;
    ram_addr        = '0;
    ram_wdata       = '0;
    ram_write_mode  = '0;
    ram_read_mode   = '0;
    ram_read_signed = 1'b0;
    if (gnt0) begin
      ram_we          = p0.we;
      ram_addr        = p0.addr;
      ram_wdata       = p0.wdata;
      ram_write_mode  = p0.size;
      ram_read_mode   = p0.size;
      ram_read_signed = p0.rd_signed;
    end else if (gnt1) begin
      ram_we          = p1.we;
      ram_addr        = p1.addr;
      ram_wdata       = p1.wdata;
      ram_write_mode  = p1.size;
      ram_read_mode   = p1.size;
      ram_read_signed = p1.rd_signed;
    end
  end

  // Tag each granted read with its port so the response can be routed back.
  always_comb begin
    resp_in.valid = (gnt0 && !p0.we) || (gnt1 && !p1.we);
    resp_in.port  = gnt1 ? ARB_P1 : ARB_P0;
  end

  mem_arb_resp_pipe #(
    .RD_LAT (RD_LAT)
  ) u_resp_pipe (
    .clk      (clk),
    .rst      (rst),
    .resp_in  (resp_in),
    .resp_out (resp_out)
  );

  assign rvalid0 = !rst && resp_out.valid && (resp_out.port == ARB_P0);
  assign rvalid1 = !rst && resp_out.valid && (resp_out.port == ARB_P1);

  assign p0.gnt    = gnt0;
  assign p1.gnt    = gnt1;
  assign p0.rvalid = rvalid0;
  assign p1.rvalid = rvalid1;
  assign p0.rdata  = rvalid0 ? ram_rdata : '0;
  assign p1.rdata  = rvalid1 ? ram_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table, directed multi-cycle sequences and
// a randomized run against a behavioural arbitration/RAM model.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;
  localparam int TMO    = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) p0_if ();
  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) p1_if ();
  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) q0_if ();
  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) q1_if ();

  logic        ram1_we, ram1_rs, ram3_we, ram3_rs;
  logic [15:0] ram1_addr, ram3_addr;
  logic [31:0] ram1_wdata, ram1_rdata, ram3_wdata, ram3_rdata;
  logic [1:0]  ram1_wm, ram1_rm, ram3_wm, ram3_rm;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(1), .LOCK_TMO(TMO)) dut (
    .clk(clk), .rst(rst), .p0(p0_if), .p1(p1_if),
    .ram_we(ram1_we), .ram_addr(ram1_addr), .ram_wdata(ram1_wdata),
    .ram_write_mode(ram1_wm), .ram_read_mode(ram1_rm), .ram_read_signed(ram1_rs),
    .ram_rdata(ram1_rdata)
  );

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(3), .LOCK_TMO(TMO)) dut3 (
    .clk(clk), .rst(rst), .p0(q0_if), .p1(q1_if),
    .ram_we(ram3_we), .ram_addr(ram3_addr), .ram_wdata(ram3_wdata),
    .ram_write_mode(ram3_wm), .ram_read_mode(ram3_rm), .ram_read_signed(ram3_rs),
    .ram_rdata(ram3_rdata)
  );

  // Word-addressed RAM models; contents restored on every reset.
  function automatic logic [31:0] init_word(int i);
    if (i == 'h40) return 32'hDEADBEEF;
    return 32'hC0DE0000 | 32'(i * 257);
  endfunction

  logic [31:0] mem1 [256];
  logic [31:0] mem3 [256];
  logic [31:0] rd3  [3];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem1[i] <= init_word(i);
    end else if (ram1_we) begin
      mem1[ram1_addr[9:2]] <= ram1_wdata;
    end
    ram1_rdata <= mem1[ram1_addr[9:2]];
  end

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem3[i] <= init_word(i);
    end else if (ram3_we) begin
      mem3[ram3_addr[9:2]] <= ram3_wdata;
    end
    rd3[0] <= mem3[ram3_addr[9:2]];
    rd3[1] <= rd3[0];
    rd3[2] <= rd3[1];
  end
  assign ram3_rdata = rd3[2];

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic drv0(input logic r, input logic w, input logic l, input logic [15:0] a,
                      input logic [31:0] d, input logic [1:0] z, input logic s);
    p0_if.req = r; p0_if.we = w; p0_if.lock = l; p0_if.addr = a;
    p0_if.wdata = d; p0_if.size = z; p0_if.rd_signed = s;
  endtask

  task automatic drv1(input logic r, input logic w, input logic l, input logic [15:0] a,
                      input logic [31:0] d, input logic [1:0] z, input logic s);
    p1_if.req = r; p1_if.we = w; p1_if.lock = l; p1_if.addr = a;
    p1_if.wdata = d; p1_if.size = z; p1_if.rd_signed = s;
  endtask

  task automatic idle_all();
    drv0(1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 2'd0, 1'b0);
    drv1(1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 2'd0, 1'b0);
    q0_if.req = 1'b0; q0_if.we = 1'b0; q0_if.lock = 1'b0; q0_if.addr = 16'h0;
    q0_if.wdata = 32'h0; q0_if.size = 2'd0; q0_if.rd_signed = 1'b0;
    q1_if.req = 1'b0; q1_if.we = 1'b0; q1_if.lock = 1'b0; q1_if.addr = 16'h0;
    q1_if.wdata = 32'h0; q1_if.size = 2'd0; q1_if.rd_signed = 1'b0;
  endtask

  task automatic do_reset();
    idle_all();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  typedef struct {
    logic r0, w0, l0; logic [15:0] a0; logic [31:0] d0; logic [1:0] z0; logic s0;
    logic r1, w1, l1; logic [15:0] a1; logic [31:0] d1; logic [1:0] z1; logic s1;
    logic [1:0] eg; logic ewe; logic [15:0] ea; logic [31:0] ed; logic [1:0] em; logic es;
  } vec_t;

  typedef struct {
    int          due;
    int          port;
    logic [31:0] data;
  } rsp_t;

  vec_t        vt [9];
  rsp_t        rq [$];
  logic [31:0] mmem [int];
  int          owner, last, idle, eg, thr;
  logic        pend [2];
  logic        we_r [2];
  logic        lk_r [2];
  logic [15:0] ad_r [2];
  logic [31:0] wd_r [2];
  logic [1:0]  exp_rv;
  logic [31:0] exp_d;
  logic        seen;

  initial begin
    // Vector table: one cycle per row from reset; expected {g1,g0}, ram_we, addr, wdata, mode, signed.
    vt[0] = '{1'b0,1'b0,1'b0,16'h0000,32'h0,SIZE_BYTE,1'b0, 1'b0,1'b0,1'b0,16'h0000,32'h0,SIZE_BYTE,1'b0,
              2'b00,1'b0,16'h0000,32'h0,2'd0,1'b0};
    vt[1] = '{1'b0,1'b0,1'b0,16'h0000,32'h0,SIZE_BYTE,1'b0, 1'b1,1'b0,1'b0,16'h0010,32'h0,SIZE_HALF,1'b1,
              2'b10,1'b0,16'h0010,32'h0,SIZE_HALF,1'b1};
    vt[2] = '{1'b1,1'b1,1'b0,16'h0020,32'hAB,SIZE_BYTE,1'b0, 1'b1,1'b0,1'b0,16'h0030,32'h0,SIZE_WORD,1'b0,
              2'b01,1'b1,16'h0020,32'hAB,SIZE_BYTE,1'b0};
    vt[3] = '{1'b1,1'b0,1'b0,16'h0024,32'h0,SIZE_WORD,1'b0, 1'b1,1'b0,1'b0,16'h0030,32'h0,SIZE_WORD,1'b0,
              2'b10,1'b0,16'h0030,32'h0,SIZE_WORD,1'b0};
    vt[4] = '{1'b1,1'b0,1'b0,16'h0024,32'h0,SIZE_WORD,1'b0, 1'b1,1'b1,1'b0,16'h0034,32'h5555AAAA,SIZE_HALF,1'b0,
              2'b01,1'b0,16'h0024,32'h0,SIZE_WORD,1'b0};
    vt[5] = '{1'b0,1'b0,1'b1,16'h0000,32'h0,SIZE_BYTE,1'b0, 1'b1,1'b1,1'b0,16'h0034,32'h5555AAAA,SIZE_HALF,1'b0,
              2'b10,1'b1,16'h0034,32'h5555AAAA,SIZE_HALF,1'b0};
    vt[6] = '{1'b0,1'b0,1'b0,16'h0000,32'h0,SIZE_BYTE,1'b0, 1'b1,1'b0,1'b0,16'h0044,32'h0,SIZE_WORD,1'b0,
              2'b10,1'b0,16'h0044,32'h0,SIZE_WORD,1'b0};
    vt[7] = '{1'b1,1'b0,1'b0,16'h0048,32'h0,SIZE_WORD,1'b0, 1'b1,1'b0,1'b0,16'h004C,32'h0,SIZE_WORD,1'b1,
              2'b01,1'b0,16'h0048,32'h0,SIZE_WORD,1'b0};
    vt[8] = '{1'b0,1'b0,1'b0,16'h0000,32'h0,SIZE_BYTE,1'b0, 1'b1,1'b0,1'b0,16'h004C,32'h0,SIZE_WORD,1'b1,
              2'b10,1'b0,16'h004C,32'h0,SIZE_WORD,1'b1};

    // Grant is held off while reset is asserted.
    idle_all();
    drv0(1'b1, 1'b0, 1'b0, 16'h0, 32'h0, SIZE_WORD, 1'b0);
    drv1(1'b1, 1'b0, 1'b0, 16'h4, 32'h0, SIZE_WORD, 1'b0);
    tick();
    settle();
    chk("rst gnt", 64'({p1_if.gnt, p0_if.gnt}), 64'(2'b00));

    // Reset state of all outputs.
    do_reset();
    settle();
    chk("reset outs", 64'({p0_if.gnt, p1_if.gnt, p0_if.rvalid, p1_if.rvalid, ram1_we, ram1_addr,
                           ram1_wdata[7:0], ram1_wm, ram1_rm, ram1_rs}), 64'h0);
    chk("reset rdata", {p1_if.rdata, p0_if.rdata}, 64'h0);

    // Vector table.
    for (int i = 0; i < 9; i++) begin
      drv0(vt[i].r0, vt[i].w0, vt[i].l0, vt[i].a0, vt[i].d0, vt[i].z0, vt[i].s0);
      drv1(vt[i].r1, vt[i].w1, vt[i].l1, vt[i].a1, vt[i].d1, vt[i].z1, vt[i].s1);
      settle();
      chk($sformatf("vec%0d", i),
          64'({p1_if.gnt, p0_if.gnt, ram1_we, ram1_addr, ram1_wdata, ram1_rm, ram1_wm, ram1_rs}),
          64'({vt[i].eg, vt[i].ewe, vt[i].ea, vt[i].ed, vt[i].em, vt[i].em, vt[i].es}));
      tick();
    end

    // Single p0 read returns RAM data one cycle later, for exactly one cycle.
    do_reset();
    drv0(1'b1, 1'b0, 1'b0, 16'h0100, 32'h0, SIZE_WORD, 1'b0);
    settle();
    chk("t1 gnt", 64'({p1_if.gnt, p0_if.gnt}), 64'(2'b01));
    tick();
    idle_all();
    settle();
    chk("t1 rvalid", 64'({p1_if.rvalid, p0_if.rvalid}), 64'(2'b01));
    chk("t1 rdata", 64'(p0_if.rdata), 64'(32'hDEADBEEF));
    chk("t1 p1 rdata", 64'(p1_if.rdata), 64'h0);
    tick();
    settle();
    chk("t1 one shot", 64'(p0_if.rvalid), 64'h0);

    // Continuous reads on both ports alternate, responses follow one cycle behind.
    do_reset();
    for (int k = 0; k < 7; k++) begin
      drv0(k < 6, 1'b0, 1'b0, 16'h0000, 32'h0, SIZE_WORD, 1'b0);
      drv1(k < 6, 1'b0, 1'b0, 16'h0004, 32'h0, SIZE_WORD, 1'b0);
      settle();
      chk($sformatf("t2 gnt%0d", k), 64'({p1_if.gnt, p0_if.gnt}),
          64'((k >= 6) ? 2'b00 : ((k % 2 == 0) ? 2'b01 : 2'b10)));
      exp_rv = (k == 0) ? 2'b00 : (((k - 1) % 2 == 0) ? 2'b01 : 2'b10);
      chk($sformatf("t2 rv%0d", k), 64'({p1_if.rvalid, p0_if.rvalid}), 64'(exp_rv));
      chk($sformatf("t2 rd%0d", k), {p1_if.rdata, p0_if.rdata},
          {exp_rv[1] ? init_word(1) : 32'h0, exp_rv[0] ? init_word(0) : 32'h0});
      tick();
    end

    // Write then read of the same address on the following cycle.
    do_reset();
    drv0(1'b1, 1'b1, 1'b0, 16'h0200, 32'h12345678, SIZE_WORD, 1'b0);
    settle();
    chk("t3 wr", 64'({p0_if.gnt, ram1_we, ram1_wm}), 64'({1'b1, 1'b1, SIZE_WORD}));
    tick();
    drv0(1'b0, 1'b0, 1'b0, 16'h0, 32'h0, SIZE_BYTE, 1'b0);
    drv1(1'b1, 1'b0, 1'b0, 16'h0200, 32'h0, SIZE_WORD, 1'b0);
    settle();
    chk("t3 rd", 64'({p1_if.gnt, ram1_we}), 64'(2'b10));
    tick();
    idle_all();
    settle();
    chk("t3 data", 64'({p1_if.rvalid, ram1_we, p1_if.rdata}), 64'({2'b10, 32'h12345678}));

    // p1 locks, p0 waits until the cycle after p1's unlocking write.
    do_reset();
    drv1(1'b1, 1'b0, 1'b1, 16'h000C, 32'h0, SIZE_WORD, 1'b0);
    settle();
    chk("t4 c0", 64'({p1_if.gnt, p0_if.gnt}), 64'(2'b10));
    tick();
    drv1(1'b0, 1'b0, 1'b0, 16'h0, 32'h0, SIZE_WORD, 1'b0);
    drv0(1'b1, 1'b0, 1'b0, 16'h0008, 32'h0, SIZE_WORD, 1'b0);
    settle();
    chk("t4 c1", 64'({p1_if.gnt, p0_if.gnt}), 64'(2'b00));
    tick();
    drv1(1'b1, 1'b1, 1'b0, 16'h000C, 32'h1, SIZE_WORD, 1'b0);
    settle();
    chk("t4 c2", 64'({p1_if.gnt, p0_if.gnt}), 64'(2'b10));
    tick();
    drv1(1'b1, 1'b0, 1'b0, 16'h0010, 32'h0, SIZE_WORD, 1'b0);
    settle();
    chk("t4 c3", 64'({p1_if.gnt, p0_if.gnt}), 64'(2'b01));
    tick();

    // Lock timeout: p0 locks and goes idle, p1 granted on the 16th cycle.
    do_reset();
    drv0(1'b1, 1'b0, 1'b1, 16'h0010, 32'h0, SIZE_WORD, 1'b0);
    drv1(1'b1, 1'b0, 1'b0, 16'h0014, 32'h0, SIZE_WORD, 1'b0);
    settle();
    chk("t5 lock", 64'({p1_if.gnt, p0_if.gnt}), 64'(2'b01));
    tick();
    drv0(1'b0, 1'b0, 1'b0, 16'h0, 32'h0, SIZE_WORD, 1'b0);
    for (int c = 1; c <= 16; c++) begin
      settle();
      chk($sformatf("t5 c%0d", c), 64'(p1_if.gnt), 64'(c == 16));
      tick();
    end
    idle_all();

    // RD_LAT=3 read killed by reset, then p0 wins the first tie.
    do_reset();
    q0_if.req = 1'b1; q0_if.addr = 16'h0100; q0_if.size = SIZE_WORD;
    settle();
    chk("t6 gnt", 64'(q0_if.gnt), 64'h1);
    tick();
    q0_if.req = 1'b0;
    rst = 1'b1;
    seen = 1'b0;
    settle();
    seen = seen | q0_if.rvalid | q1_if.rvalid;
    tick();
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      settle();
      seen = seen | q0_if.rvalid | q1_if.rvalid;
      tick();
    end
    chk("t6 no rvalid", 64'(seen), 64'h0);
    q0_if.req = 1'b1;
    q1_if.req = 1'b1;
    settle();
    chk("t6 post rst", 64'({q1_if.gnt, q0_if.gnt}), 64'(2'b01));
    tick();
    idle_all();

    // Randomized traffic against the behavioural model.
    do_reset();
    owner = -1;
    last  = 1;
    idle  = 0;
    mmem.delete();
    rq.delete();
    for (int p = 0; p < 2; p++) begin
      pend[p] = 1'b0; we_r[p] = 1'b0; lk_r[p] = 1'b0; ad_r[p] = 16'h0; wd_r[p] = 32'h0;
    end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      thr = ((cyc / 200) % 2 == 0) ? 4 : 1;
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && ($urandom_range(0, 7) < thr)) begin
          pend[p] = 1'b1;
          we_r[p] = 1'($urandom_range(0, 1));
          lk_r[p] = ($urandom_range(0, 3) == 0);
          ad_r[p] = 16'($urandom_range(0, 15) << 2);
          wd_r[p] = $urandom;
        end
      end
      drv0(pend[0], we_r[0], pend[0] ? lk_r[0] : 1'($urandom_range(0, 1)), ad_r[0], wd_r[0], SIZE_WORD, 1'b0);
      drv1(pend[1], we_r[1], pend[1] ? lk_r[1] : 1'($urandom_range(0, 1)), ad_r[1], wd_r[1], SIZE_WORD, 1'b0);
      settle();

      eg = -1;
      if (owner < 0) begin
        if (pend[0] && pend[1]) eg = 1 - last;
        else if (pend[0]) eg = 0;
        else if (pend[1]) eg = 1;
      end else if (pend[owner]) begin
        eg = owner;
      end
      chk("rnd gnt", 64'({p1_if.gnt, p0_if.gnt}),
          64'((eg == 0) ? 2'b01 : ((eg == 1) ? 2'b10 : 2'b00)));

      exp_rv = 2'b00;
      exp_d  = 32'h0;
      if (rq.size() > 0 && rq[0].due == cyc) begin
        exp_rv = (rq[0].port == 0) ? 2'b01 : 2'b10;
        exp_d  = rq[0].data;
        void'(rq.pop_front());
      end
      chk("rnd rvalid", 64'({p1_if.rvalid, p0_if.rvalid}), 64'(exp_rv));
      chk("rnd rdata0", 64'(p0_if.rdata), 64'(exp_rv[0] ? exp_d : 32'h0));
      chk("rnd rdata1", 64'(p1_if.rdata), 64'(exp_rv[1] ? exp_d : 32'h0));

      if (eg >= 0) begin
        last = eg;
        if (we_r[eg]) begin
          mmem[int'(ad_r[eg][9:2])] = wd_r[eg];
        end else begin
          rq.push_back('{cyc + 1, eg,
                         mmem.exists(int'(ad_r[eg][9:2])) ? mmem[int'(ad_r[eg][9:2])]
                                                          : init_word(int'(ad_r[eg][9:2]))});
        end
      end
      if (owner < 0) begin
        if (eg >= 0 && lk_r[eg]) begin
          owner = eg;
          idle  = 0;
        end
      end else if (eg == owner) begin
        idle = 0;
        if (!lk_r[eg]) owner = -1;
      end else begin
        idle++;
        if (idle == TMO) begin
          owner = -1;
          idle  = 0;
        end
      end

      if (p0_if.gnt) pend[0] = 1'b0;
      if (p1_if.gnt) pend[1] = 1'b0;
      tick();
    end
    idle_all();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
